// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default latencies.
package mdu_pkg;

    // Op codes presented on the op port; 6 and 7 are reserved.
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    // Default busy durations in clock cycles.
    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core: produces HI/LO results for mult/multu/div/divu.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_b_mag_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;

    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed division on magnitudes; 0x80000000 has magnitude 2^31 as an unsigned value,
    // so the -2^31 / -1 case wraps back to 0x80000000 with no special handling.
    assign w_a_mag      = a[31] ? (~a + 32'd1) : a;
    assign w_b_mag      = b[31] ? (~b + 32'd1) : b;
    // Substitute 1 for a zero divisor so the dividers never see zero; result is discarded.
    assign w_b_safe     = (b == 32'd0) ? 32'd1 : b;
    assign w_b_mag_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_mag_safe;
    assign w_r_mag      = w_a_mag % w_b_mag_safe;
    assign w_q_u        = a / w_b_safe;
    assign w_r_u        = a % w_b_safe;

    // Select the result pair for the requested operation.
    always_comb begin
        hi_res      = 32'd0;
        lo_res      = 32'd0;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT: begin
                hi_res = w_prod_s[63:32];
                lo_res = w_prod_s[31:0];
            end
            MDU_MULTU: begin
                hi_res = w_prod_u[63:32];
                lo_res = w_prod_u[31:0];
            end
            MDU_DIV: begin
                lo_res      = (a[31] ^ b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
                hi_res      = a[31] ? (~w_r_mag + 32'd1) : w_r_mag;
                div_by_zero = (b == 32'd0);
            end
            MDU_DIVU: begin
                lo_res      = w_q_u;
                hi_res      = w_r_u;
                div_by_zero = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: IDLE/BUSY sequencer, latency counter, pending result and HI/LO registers.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    mdu_state_e  r_state;
    mdu_state_e  w_state_d;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_d;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_dbz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_pend_load;
    logic        w_commit;
    logic        w_mthi;
    logic        w_mtlo;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;
    logic        w_dbz;

    mdu_calc u_calc (
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_res      (w_hi_res),
        .lo_res      (w_lo_res),
        .div_by_zero (w_dbz)
    );

    // Next-state, counter and strobe decode; start is only honoured in IDLE.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_pend_load = 1'b0;
        w_commit    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            w_pend_load = 1'b1;
                            w_cnt_d     = MULT_N;
                            w_state_d   = StBusy;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            w_pend_load = 1'b1;
                            w_cnt_d     = DIV_N;
                            w_state_d   = StBusy;
                        end
                        MDU_MTHI: w_mthi = 1'b1;
                        MDU_MTLO: w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                // Count of 1 marks the last busy cycle; commit on the edge that ends it.
                if (r_cnt <= 4'd1) begin
                    w_commit  = 1'b1;
                    w_cnt_d   = 4'd0;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Capture the arithmetic result when an operation is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_hi  <= 32'd0;
            r_pend_lo  <= 32'd0;
            r_pend_dbz <= 1'b0;
        end else if (w_pend_load) begin
            r_pend_hi  <= w_hi_res;
            r_pend_lo  <= w_lo_res;
            r_pend_dbz <= w_dbz;
        end
    end

    // Architectural HI/LO: updated by commit (unless divide by zero) or by MTHI/MTLO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_commit && !r_pend_dbz) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
        end
    end

    assign busy  = (r_state == StBusy);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign rdata = rd_sel ? r_hi : r_lo;

endmodule
